// File: rtl/async_fifo_wr_packer.sv
// async_fifo_wr_packer: packs RATIO narrow beats into one FIFO word and writes it into async_fifo.
// Optional idle auto-flush is enabled by defining ASYNC_FIFO_PACKER_TIMEOUT_EN.
`default_nettype none

module async_fifo_wr_packer #(
   parameter int IN_WIDTH       = 8,
   parameter int RATIO          = 4,
   parameter int FIFO_WIDTH     = IN_WIDTH * RATIO,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  fifo_wclk,
   input  logic                  fifo_wrst_n,
   input  logic                  in_valid,
   input  logic [IN_WIDTH-1:0]   in_data,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic                  fifo_wen,
   output logic [FIFO_WIDTH-1:0] fifo_wdata,
   input  logic                  fifo_full,
   output logic [31:0]           word_cnt
);

   localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

   if (RATIO < 1 || RATIO > 16 || FIFO_WIDTH != IN_WIDTH * RATIO || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("async_fifo_wr_packer: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      PUSH = 2'd2
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [LANE_W-1:0]     lane_cnt;
   logic [LANE_W-1:0]     lane_d;
   logic [FIFO_WIDTH-1:0] acc_q;
   logic [FIFO_WIDTH-1:0] acc_d;
   logic [FIFO_WIDTH-1:0] merged;
   logic [FIFO_WIDTH-1:0] wdata_d;
   logic                  pending;
   logic                  accept;
   logic                  last_lane;
   logic                  load;
   logic                  flush;

   assign pending   = (state_q == PUSH);
   assign in_ready  = fifo_wrst_n && (!pending || !fifo_full);
   assign fifo_wen  = pending && !fifo_full;
   assign accept    = in_valid && in_ready;
   assign last_lane = (lane_cnt == LANE_W'(RATIO - 1));

`ifdef ASYNC_FIFO_PACKER_TIMEOUT_EN
   logic [15:0] idle_cnt;
   logic        idle_cycle;

   assign idle_cycle = (lane_cnt != '0) && !accept;
   // Counter saturates one short of the limit so a flush blocked by pending fires as soon as it clears.
   assign flush      = idle_cycle && (idle_cnt >= 16'(TIMEOUT_CYCLES - 1)) && !pending;

   always_ff @(posedge fifo_wclk or negedge fifo_wrst_n) begin
      if (!fifo_wrst_n) begin
         idle_cnt <= '0;
      end else if (accept || flush) begin
         idle_cnt <= '0;
      end else if (idle_cycle && (idle_cnt < 16'(TIMEOUT_CYCLES - 1))) begin
         idle_cnt <= idle_cnt + 16'd1;
      end
   end
`else
   assign flush = 1'b0;
`endif

   always_comb begin
      merged = acc_q;
      for (int k = 0; k < RATIO; k++) begin
         if (lane_cnt == LANE_W'(k)) begin
            merged[k*IN_WIDTH +: IN_WIDTH] = in_data;
         end
      end

      load    = 1'b0;
      lane_d  = lane_cnt;
      acc_d   = acc_q;
      wdata_d = fifo_wdata;

      if (accept) begin
         if (last_lane || in_last) begin
            load    = 1'b1;
            wdata_d = merged;
            acc_d   = '0;
            lane_d  = '0;
         end else begin
            acc_d  = merged;
            lane_d = lane_cnt + LANE_W'(1);
         end
      end else if (flush) begin
         load    = 1'b1;
         wdata_d = acc_q;
         acc_d   = '0;
         lane_d  = '0;
      end

      // A new word loaded in the same cycle as a push keeps the word slot occupied.
      if (load || (pending && !fifo_wen)) begin
         state_d = PUSH;
      end else if (lane_d != '0) begin
         state_d = FILL;
      end else begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge fifo_wclk or negedge fifo_wrst_n) begin
      if (!fifo_wrst_n) begin
         state_q    <= IDLE;
         lane_cnt   <= '0;
         acc_q      <= '0;
         fifo_wdata <= '0;
         word_cnt   <= '0;
      end else begin
         state_q    <= state_d;
         lane_cnt   <= lane_d;
         acc_q      <= acc_d;
         fifo_wdata <= wdata_d;
         if (fifo_wen) begin
            word_cnt <= word_cnt + 32'd1;
         end
      end
   end

endmodule

`default_nettype wire

// File: doc/async_fifo_wr_packer.md
Name: async_fifo_wr_packer

Overview:
Write-side upstream stage of async_fifo, running in the FIFO write clock domain. Accepts a narrow valid/ready byte stream and packs RATIO consecutive beats into one FIFO_WIDTH word, then drives fifo_wen/fifo_wdata into async_fifo while honouring fifo_full. Partial words are flushed, zero-padded, on in_last.

Parameters:
IN_WIDTH, 8, width of one input beat (lane)
RATIO, 4, beats per FIFO word; legal range 1..16
FIFO_WIDTH, IN_WIDTH*RATIO, output word width; must equal async_fifo FIFO_WIDTH
TIMEOUT_CYCLES, 16, idle cycles before an auto-flush; used only with the optional feature

Ports:
fifo_wclk  in  1  write-domain clock; all logic on rising edge
fifo_wrst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_data  in  IN_WIDTH  input beat data
in_last  in  1  beat closes the current word; flush even if partial
in_ready  out  1  block accepts beat this cycle
fifo_wen  out  1  write strobe to async_fifo
fifo_wdata  out  FIFO_WIDTH  packed word to async_fifo
fifo_full  in  1  async_fifo full flag (write-domain)
word_cnt  out  32  count of words written (fifo_wen cycles)

Behaviour:
- Reset (async assert, sync release): in_ready=0 while fifo_wrst_n=0; fifo_wen=0, fifo_wdata=0, word_cnt=0, lane_cnt=0, accumulator=0, pending=0. Reset mid-operation discards any partial or pending word.
- Accept: beat accepted when in_valid && in_ready. Lane ordering is little-endian: beat k of a word occupies bits [k*IN_WIDTH +: IN_WIDTH].
- Completion: an accepted beat completes the word when lane_cnt==RATIO-1 or in_last=1. On completion:
  - fifo_wdata_q <= accumulator merged with this beat; unfilled lanes are 0.
  - pending <= 1.
  - accumulator <= 0 and lane_cnt <= 0.
  - Otherwise lane_cnt increments.
- States:
  - IDLE: lane_cnt=0, !pending.
  - FILL: lane_cnt>0, !pending.
  - PUSH: pending. FILL activity continues independently while in PUSH.
- Write: fifo_wen = pending && !fifo_full, combinational. fifo_wdata is a registered output and holds while pending. On fifo_wen, pending clears next edge and word_cnt increments (wraps at 2^32).
- in_ready = fifo_wrst_n && (!pending || !fifo_full).
- Simultaneous push + completing beat: the new word loads fifo_wdata_q and pending stays 1, so full rate is 1 beat/cycle. A completing beat can never be accepted while pending && fifo_full.
- fifo_full asserted while pending: fifo_wen=0 and the word is held indefinitely; no data is lost or duplicated.
- Latency: a completing beat accepted at cycle N gives fifo_wen at N+1 if !fifo_full.
- RATIO=1: every accepted beat completes a word. in_last has no extra effect.

Optional Feature:
ASYNC_FIFO_PACKER_TIMEOUT_EN
- Defined: a 16-bit idle counter.
  - Counts cycles with lane_cnt>0 and no accepted beat; clears on any accepted beat or flush.
  - On reaching TIMEOUT_CYCLES with !pending, the partial word is flushed zero-padded exactly as for in_last.
  - If pending is set at that point, the flush occurs on the first cycle pending is clear.
- Not defined: no counter; a partial word waits indefinitely for more beats or in_last.

Test Plan:
- Reset: hold fifo_wrst_n=0 with in_valid=1 -> in_ready=0, fifo_wen=0, fifo_wdata=0, word_cnt=0; after release, in_ready=1.
- Full-rate pack: beats 01,02,03,04,05..08 back-to-back, fifo_full=0 -> fifo_wen pulses carrying 32'h04030201 then 32'h08070605; word_cnt=2; in_ready stays 1.
- Partial flush: beats AA,BB with in_last on BB -> single write of 32'h0000BBAA one cycle later.
- Backpressure: word 32'h44332211 pending with fifo_full=1 for 5 cycles; send 3 non-completing beats then a completing one -> fifo_wen=0 throughout, in_ready=0; on fifo_full=0, writes 32'h44332211 exactly once, then accepts and continues; no loss or duplication.
- Reset mid-word: 2 beats accepted, then pulse reset -> no write; next 4 beats 10,20,30,40 -> 32'h40302010.
- Timeout (macro defined, TIMEOUT_CYCLES=16): one beat 5A then idle -> write of 32'h0000005A 17 cycles after acceptance; with macro undefined -> no write after 100 idle cycles.
